line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
//
// PURPOSE
//  Sequences the KERNEL-1 dp_bram line buffers of the 2D FIR front end. Accepts a raster
//  pixel stream, writes each pixel into the buffer holding the oldest row, and reads all
//  buffers at the same column. Emits one vertical KERNEL-pixel column per accepted pixel to
//  the window/MAC stage. Owns the column/row counters, buffer rotation and frame sequencing.
//
// PARAMETERS
//  IMG_W    1920  active pixels per row; must be <= 2000 (BRAM DEPTH) and < 2**ADDR_W
//  IMG_H    1080  rows per frame; must be >= KERNEL
//  KERNEL   3     kernel height; NBUF = KERNEL-1 line buffers driven
//  ADDR_W   11    BRAM address width
//
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  rst          in   1            asynchronous, active-high reset
//  start        in   1            1-cycle pulse: begin a frame (honoured in IDLE only)
//  in_valid     in   1            pixel present on in_data
//  in_data      in   8            pixel, raster order, top row first
//  in_ready     out  1            1 in FILL/RUN; pixel accepted when in_valid & in_ready
//  bram_we      out  NBUF         per-buffer port-A write enable (one-hot or 0)
//  bram_addr_a  out  ADDR_W       common write address (= current x)
//  bram_addr_b  out  ADDR_W       common read address (= current x)
//  bram_din     out  8            write data (= in_data)
//  bram_dout    in   NBUF*8       port-B read data, buffer i at [8i+7:8i], 1-cycle latency
//  out_valid    out  1            column valid
//  out_col      out  KERNEL*8     [7:0]=row y, [15:8]=row y-1, ... top = row y-(KERNEL-1)
//  out_x        out  ADDR_W       column of out_col
//  out_y        out  11           row of out_col
//  out_full     out  1            1 when out_y >= KERNEL-1 (all rows in out_col are real)
//  busy         out  1            1 in FILL/RUN
//  done         out  1            1-cycle pulse after last pixel of frame is emitted
//
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-frame): state=IDLE, x=y=0, wr_sel=0; in_ready,
//    bram_we, out_valid, out_col, out_x, out_y, out_full, busy, done all 0. BRAM contents
//    not cleared; stale data is masked by out_full.
//  - States: IDLE -start-> FILL -(y reaches KERNEL-1 at row wrap)-> RUN -(last pixel
//    accepted)-> DONE -(1 cycle)-> IDLE. start outside IDLE ignored.
//  - Accept cycle (in_valid & in_ready): bram_we[wr_sel]=1, addr_a=addr_b=x,
//    bram_din=in_data (combinational from x/in_data). Other bram_we bits 0; none when idle.
//  - dp_bram is read-first: buffer wr_sel returns row y-(KERNEL-1) at x before overwrite.
//    Other buffers hold rows y-1..y-(KERNEL-2) in rotation order.
//  - Latency 1: the cycle after accept, out_valid=1. out_col row y = registered in_data.
//    Older rows come from bram_dout, reordered by the registered wr_sel/rotation.
//    out_x/out_y are the registered x/y. No accept -> out_valid=0, other outputs hold.
//  - Counters: x increments on accept. When x==IMG_W-1: x->0, y++,
//    wr_sel->(wr_sel+1) mod NBUF. Last pixel is x==IMG_W-1, y==IMG_H-1: enter DONE,
//    in_ready=0. The final column is emitted in DONE's cycle, with done=1 in that same cycle.
//  - in_valid gaps are legal anywhere; counters hold. in_valid with in_ready=0 is dropped.
//  - FILL: columns are still emitted with out_full=0 (top rows contain stale data).
//  - No output back-pressure: the consumer must accept one column per cycle.
//
// STRUCTURE
//  - Shared package fir2d_pkg: PIX_W=8, ADDR_W, KERNEL, NBUF, state enum
//    {IDLE,FILL,RUN,DONE}, BRAM DEPTH=2000.
//  - One sub-module: pix_coord_counter (x/y counters with enable, wrap flags, last flag).
//  - Top level instantiates NBUF dp_bram outside this block; this block only drives ports.
//
// TESTING  (bench: IMG_W=4, IMG_H=4, KERNEL=3, behavioural dp_bram models)
//  1 reset then start; feed pixel values 0..15 with no gaps -> 16 out_valid pulses, each
//    1 cycle after its accept. Column (x=1,y=2) out_col={8'd1,8'd5,8'd9}; done after 16th.
//  2 rows 0-1 -> out_full=0; from (0,2) on -> out_full=1. bram_we rotates 01,10,01,10 per row.
//  3 in_valid toggled 1/0 every cycle -> identical out_col sequence as test 1; counters
//    hold during gaps; out_valid never asserts for gap cycles.
//  4 start pulse during RUN -> ignored (x,y continue); in_valid in IDLE -> in_ready=0,
//    no bram_we, no out_valid.
//  5 rst asserted asynchronously at (x=2,y=1) -> all outputs 0 immediately. Restart with
//    values 100..115 -> outputs match test 1 pattern +100; out_full masks stale rows 0-1.
//  6 two back-to-back frames (start the cycle after done) -> second frame's y=2 column
//    uses only second-frame data.

Source files
------------

// File: rtl/fir2d_pkg.sv
// Shared types and constants for the 2D FIR front end.
package fir2d_pkg;

  localparam int PIX_W      = 8;
  localparam int ADDR_W     = 11;
  localparam int KERNEL     = 3;
  localparam int NBUF       = KERNEL - 1;
  localparam int BRAM_DEPTH = 2000;
  localparam int OUT_Y_W    = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Buffer index holding row (y - k), given that buffer 'sel' holds row (y - nbuf).
  function automatic int rot_index(input int sel, input int k, input int nbuf);
    int idx;
    idx = sel + nbuf - k;
    if (idx >= nbuf) begin
      idx = idx - nbuf;
    end else begin
      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pix_coord_counter.sv
// Raster x/y coordinate counters with row-wrap and end-of-frame flags.
module pix_coord_counter #(
  parameter int IMG_W = 1920,
  parameter int IMG_H = 1080,
  parameter int X_W   = 11,
  parameter int Y_W   = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           x_wrap,
  output logic           last
);

  assign x_wrap = (x == X_W'(IMG_W - 1));
  assign last   = x_wrap && (y == Y_W'(IMG_H - 1));

  // Advance one pixel per enable; wrap x at row end and y at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_wrap) begin
        x <= '0;
        y <= last ? '0 : (y + Y_W'(1));
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer sequencer: writes the oldest row buffer, reads all buffers at the
// same column and emits one vertical KERNEL-pixel column per accepted pixel.
module line_buffer_ctrl
  import fir2d_pkg::*;
#(
  parameter int IMG_W  = 1920,
  parameter int IMG_H  = 1080,
  parameter int KERNEL = fir2d_pkg::KERNEL,
  parameter int ADDR_W = fir2d_pkg::ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [KERNEL-2:0]             bram_we,
  output logic [ADDR_W-1:0]             bram_addr_a,
  output logic [ADDR_W-1:0]             bram_addr_b,
  output logic [7:0]                    bram_din,
  input  logic [(KERNEL-1)*8-1:0]       bram_dout,
  output logic                          out_valid,
  output logic [KERNEL*8-1:0]           out_col,
  output logic [ADDR_W-1:0]             out_x,
  output logic [10:0]                   out_y,
  output logic                          out_full,
  output logic                          busy,
  output logic                          done
);

  localparam int NBUF  = KERNEL - 1;
  localparam int SEL_W = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int Y_W   = OUT_Y_W;

  state_t                    state;
  logic [ADDR_W-1:0]         x;
  logic [Y_W-1:0]            y;
  logic                      x_wrap;
  logic                      last;
  logic                      accept;
  logic                      frame_start;
  logic [SEL_W-1:0]          wr_sel;
  logic [SEL_W-1:0]          sel_r;
  logic [PIX_W-1:0]          pix_r;
  logic [KERNEL*PIX_W-1:0]   col_live;
  logic [KERNEL*PIX_W-1:0]   col_hold;

  assign in_ready    = (state == FILL) || (state == RUN);
  assign busy        = in_ready;
  assign accept      = in_valid && in_ready;
  assign frame_start = start && (state == IDLE);

  assign bram_addr_a = x;
  assign bram_addr_b = x;
  assign bram_din    = in_data;

  pix_coord_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X_W   (ADDR_W),
    .Y_W   (Y_W)
  ) u_coord (
    .clk    (clk),
    .rst    (rst),
    .clear  (frame_start),
    .en     (accept),
    .x      (x),
    .y      (y),
    .x_wrap (x_wrap),
    .last   (last)
  );

  // Write only the buffer holding the oldest row, and only on an accepted pixel.
  always_comb begin
    bram_we = '0;
    if (accept) begin
      bram_we[wr_sel] = 1'b1;
    end else begin
      bram_we = '0;
    end
  end

  // Frame sequencing, buffer rotation and registered column metadata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_sel    <= '0;
      sel_r     <= '0;
      pix_r     <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_full  <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= accept;
      done      <= accept && last;
      if (accept) begin
        pix_r    <= in_data;
        out_x    <= x;
        out_y    <= y;
        out_full <= (y >= Y_W'(KERNEL - 1));
        sel_r    <= wr_sel;
      end
      if (frame_start) begin
        wr_sel <= '0;
      end else if (accept && x_wrap) begin
        wr_sel <= (wr_sel == SEL_W'(NBUF - 1)) ? '0 : (wr_sel + SEL_W'(1));
      end
      case (state)
        IDLE: if (start) state <= FILL;
        FILL: if (accept && x_wrap && (y == Y_W'(KERNEL - 2))) state <= RUN;
        RUN:  if (accept && last) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Assemble the column: newest row from the pixel register, older rows from
  // the buffers reordered so that slot k carries row y-k.
  always_comb begin
    col_live = '0;
    col_live[PIX_W-1:0] = pix_r;
    for (int k = 1; k < KERNEL; k++) begin
      col_live[k*PIX_W +: PIX_W] = bram_dout[rot_index(int'(sel_r), k, NBUF)*PIX_W +: PIX_W];
    end
  end

  // Keep the last emitted column so out_col holds while no column is valid,
  // even though the buffer read data keeps moving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_hold <= '0;
    end else if (out_valid) begin
      col_hold <= col_live;
    end
  end

  assign out_col = out_valid ? col_live : col_hold;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a 4x4 image, 3-row kernel and
// behavioural read-first line buffers.
module tb_line_buffer_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [1:0]  bram_we;
  logic [10:0] bram_addr_a;
  logic [10:0] bram_addr_b;
  logic [7:0]  bram_din;
  logic [15:0] bram_dout;
  logic        out_valid;
  logic [23:0] out_col;
  logic [10:0] out_x;
  logic [10:0] out_y;
  logic        out_full;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  logic [7:0] mem0 [0:15];
  logic [7:0] mem1 [0:15];

  line_buffer_ctrl #(
    .IMG_W  (4),
    .IMG_H  (4),
    .KERNEL (3),
    .ADDR_W (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .bram_we     (bram_we),
    .bram_addr_a (bram_addr_a),
    .bram_addr_b (bram_addr_b),
    .bram_din    (bram_din),
    .bram_dout   (bram_dout),
    .out_valid   (out_valid),
    .out_col     (out_col),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_full    (out_full),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 8'hEE;
      mem1[i] = 8'hEE;
    end
  end

  // Two read-first dual-port buffers, one-cycle read latency.
  always @(posedge clk) begin
    bram_dout[7:0]  <= mem0[bram_addr_b[3:0]];
    bram_dout[15:8] <= mem1[bram_addr_b[3:0]];
    if (bram_we[0]) mem0[bram_addr_a[3:0]] <= bram_din;
    if (bram_we[1]) mem1[bram_addr_a[3:0]] <= bram_din;
  end

  task automatic start_pulse(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s start_busy got=%0b exp=1", tag, busy);
    end
  endtask

  // Feed npix pixels base+p; optional gaps and a stray start at pixel start_at.
  task automatic feed_frame(input int base, input int npix, input bit gappy,
                            input int start_at, input string tag);
    int p;
    int cyc;
    int ex, ey;
    logic [7:0] v0, v1, v2;
    logic [1:0] exp_we;
    p = 0;
    cyc = 0;
    while (p < npix && cyc < 200) begin
      cyc++;
      if (gappy && (cyc % 2 == 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bram_we !== 2'b00) begin
          failures++;
          $display("FAIL %s gap_we got=%b exp=00", tag, bram_we);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s gap_valid got=%0b exp=0", tag, out_valid);
        end
        checks++;
        if (out_x !== 11'((p - 1) % 4)) begin
          failures++;
          $display("FAIL %s gap_hold_x got=%0d exp=%0d", tag, out_x, (p - 1) % 4);
        end
      end else begin
        ex = p % 4;
        ey = p / 4;
        v0 = 8'(base + p);
        v1 = 8'(base + p - 4);
        v2 = 8'(base + p - 8);
        exp_we = (ey % 2 == 0) ? 2'b01 : 2'b10;
        in_valid = 1'b1;
        in_data = v0;
        start = (p == start_at) ? 1'b1 : 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || bram_we !== exp_we || bram_addr_a !== 11'(ex) ||
            bram_addr_b !== 11'(ex) || bram_din !== v0) begin
          failures++;
          $display("FAIL %s bram_port p=%0d got rdy=%0b we=%b a=%0d b=%0d din=%0d exp rdy=1 we=%b a=%0d din=%0d",
                   tag, p, in_ready, bram_we, bram_addr_a, bram_addr_b, bram_din, exp_we, ex, v0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_x !== 11'(ex) || out_y !== 11'(ey) ||
            out_full !== (ey >= 2)) begin
          failures++;
          $display("FAIL %s out_meta p=%0d got v=%0b x=%0d y=%0d full=%0b exp v=1 x=%0d y=%0d full=%0b",
                   tag, p, out_valid, out_x, out_y, out_full, ex, ey, (ey >= 2));
        end
        checks++;
        if (out_col[7:0] !== v0) begin
          failures++;
          $display("FAIL %s col_row_y p=%0d got=%0d exp=%0d", tag, p, out_col[7:0], v0);
        end
        if (ey >= 1) begin
          checks++;
          if (out_col[15:8] !== v1) begin
            failures++;
            $display("FAIL %s col_row_y1 p=%0d got=%0d exp=%0d", tag, p, out_col[15:8], v1);
          end
        end
        if (ey >= 2) begin
          checks++;
          if (out_col[23:16] !== v2) begin
            failures++;
            $display("FAIL %s col_row_y2 p=%0d got=%0d exp=%0d", tag, p, out_col[23:16], v2);
          end
        end
        checks++;
        if (done !== (p == 15)) begin
          failures++;
          $display("FAIL %s done p=%0d got=%0b exp=%0b", tag, p, done, (p == 15));
        end
        p++;
      end
    end
    in_valid = 1'b0;
    if (p < npix) begin
      failures++;
      $display("FAIL %s timeout accepted=%0d exp=%0d", tag, p, npix);
    end
    if (npix == 16) begin
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s done_state got busy=%0b rdy=%0b exp 0 0", tag, busy, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s after_done got done=%0b v=%0b busy=%0b exp 0 0 0", tag, done, out_valid, busy);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (in_ready !== 1'b0 || bram_we !== 2'b00 || out_valid !== 1'b0 || out_col !== 24'h0 ||
        out_x !== 11'd0 || out_y !== 11'd0 || out_full !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s zero_outputs got rdy=%0b we=%b v=%0b col=%h x=%0d y=%0d full=%0b busy=%0b done=%0b exp all 0",
               tag, in_ready, bram_we, out_valid, out_col, out_x, out_y, out_full, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");
  endtask

  task automatic test_stream();
    start_pulse("stream");
    feed_frame(0, 16, 1'b0, -1, "stream");
  endtask

  task automatic test_gaps();
    start_pulse("gaps");
    feed_frame(0, 16, 1'b1, -1, "gaps");
  endtask

  task automatic test_start_ignored();
    start_pulse("start_run");
    feed_frame(30, 16, 1'b0, 9, "start_run");
    in_valid = 1'b1;
    in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || bram_we !== 2'b00) begin
        failures++;
        $display("FAIL idle_input got rdy=%0b we=%b exp 0 00", in_ready, bram_we);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_valid got=%0b exp=0", out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    start_pulse("areset");
    feed_frame(0, 6, 1'b0, -1, "areset_pre");
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    start_pulse("restart");
    feed_frame(100, 16, 1'b0, -1, "restart");
  endtask

  task automatic test_back_to_back();
    start_pulse("b2b_a");
    feed_frame(200, 16, 1'b0, -1, "b2b_a");
    start_pulse("b2b_b");
    feed_frame(50, 16, 1'b0, -1, "b2b_b");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_gaps();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
